button_press_unit: RTL

//   Conditions one raw, asynchronous, bouncing pushbutton into clean single-cycle

---
 rtl/button_press_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/button_press_unit.sv
// rtl/button_press_unit.sv - pushbutton synchronizer, debounce FSM and press/long-press pulse generator
module button_press_unit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic press_pulse,
    output logic long_press,
    output logic button_level
);

    // Counter widths cover the largest value each counter can legally hold.
    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (HOLD_CYCLES > 0) ? HOLD_CYCLES : 1;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam bit HOLD_EN  = (HOLD_CYCLES > 0);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    state_t                 state;
    state_t                 state_nxt;
    logic [DEB_W-1:0]       deb_cnt;
    logic [DEB_W-1:0]       deb_nxt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      hold_nxt;
    logic                   press_nxt;
    logic                   long_nxt;
    logic                   level_nxt;

    // Multi-stage synchronizer: the raw button only ever reaches the first flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], button_in};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            deb_cnt      <= '0;
            hold_cnt     <= '0;
            press_pulse  <= 1'b0;
            long_press   <= 1'b0;
            button_level <= 1'b0;
        end else begin
            state        <= state_nxt;
            deb_cnt      <= deb_nxt;
            hold_cnt     <= hold_nxt;
            press_pulse  <= press_nxt;
            long_press   <= long_nxt;
            button_level <= level_nxt;
        end
    end

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive agreeing samples; pulses are decided here and registered.
    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        press_nxt = 1'b0;
        long_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = WAIT_HIGH;
                    deb_nxt   = DEB_ONE;
                end
            end

            WAIT_HIGH: begin
                if (!sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                end else begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end

            PRESSED: begin
                if (!sync) begin
                    state_nxt = WAIT_LOW;
                    deb_nxt   = DEB_ONE;
                end else begin
                    // hold_cnt passes HOLD_LAST only once per press because it
                    // saturates above it and is cleared only on a new press.
                    if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
                        long_nxt = 1'b1;
                    end
                    if (hold_cnt != HOLD_SAT) begin
                        hold_nxt = hold_cnt + HOLD_ONE;
                    end
                end
            end

            WAIT_LOW: begin
                if (sync) begin
                    // Release bounce: back to PRESSED with hold time preserved.
                    state_nxt = PRESSED;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase

        level_nxt = (state_nxt == PRESSED) || (state_nxt == WAIT_LOW);
    end

endmodule
